uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
//
// PURPOSE
//   Baud-rate-timed UART transmitter. Serialises one byte per valid/ready
//   handshake into a standard async frame: start, LSB-first data, optional
//   parity, stop. Sits between the receive/echo logic and the board TX pin
//   and replaces the one-bit-per-clock transmit path with real bit timing.
//
// PARAMETERS
//   CLK_HZ     12000000  system clock frequency, Hz
//   BAUD       115200    line rate; CLKS_PER_BIT = CLK_HZ/BAUD (truncated, must be >=2)
//   DATA_BITS  8         data bits per frame, 5..8
//   PARITY     0         0 = none, 1 = odd, 2 = even
//   STOP_BITS  1         stop bits, 1 or 2
//
// PORTS
//   clk        in   1          system clock, rising edge
//   reset      in   1          asynchronous, active-high reset
//   tx_data    in   8          byte to send; bits [DATA_BITS-1:0] used
//   tx_valid   in   1          tx_data holds a byte to send
//   tx_ready   out  1          engine can accept a byte this cycle
//   UART_TX    out  1          serial line, idle high
//   busy       out  1          frame in progress (state != IDLE)
//
// BEHAVIOUR
//   - Reset (async): state=IDLE, UART_TX=1, tx_ready=1, busy=0, counters=0.
//     Reset mid-frame drives UART_TX high immediately; the partial frame is dropped.
//   - Handshake: a byte is accepted on a rising clk edge where tx_valid && tx_ready.
//     tx_data is latched into the shift register at that edge; the source may
//     change it afterwards. tx_ready = (state == IDLE), registered.
//   - tx_valid while busy: ignored; nothing latched, no error.
//   - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     IDLE: UART_TX=1. On accept, the next state is START and the baud counter clears.
//     START: UART_TX=0 for CLKS_PER_BIT cycles.
//     DATA: UART_TX=shift[0] for CLKS_PER_BIT cycles per bit; shift right on
//       each bit boundary; bit index 0..DATA_BITS-1, exits after last.
//     PARITY (only if PARITY!=0): even -> XOR of data bits; odd -> its inverse.
//       Computed from the latched byte at acceptance.
//     STOP: UART_TX=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//   - Latency: UART_TX falls on the first edge after the accepting edge.
//     Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
//   - Back-to-back: tx_ready is high in the first IDLE cycle after STOP. With
//     tx_valid held, the next start bit follows exactly one idle-high clk cycle.
//   - Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and
//     wraps to 0 on bit_tick. It is held at 0 in IDLE. There is no drift
//     across frames.
//
// STRUCTURE
//   - uart_pkg: state enum/localparams (ST_IDLE, ST_START, ST_DATA, ST_PARITY,
//     ST_STOP), parity encodings (PAR_NONE/ODD/EVEN), and the clks_per_bit
//     function. It is shared with the future uart_rx_engine.
//   - Sub-module uart_baud_gen: counter with clear input; emits a one-cycle
//     bit_tick at count == CLKS_PER_BIT-1. It is reused by the RX side.
//   - The FSM, shift register, bit index and stop counter are in this module.
//
// TESTING (CLK_HZ=460800, BAUD=115200 -> CLKS_PER_BIT=4 unless noted)
//   1. Assert reset, release -> UART_TX=1, tx_ready=1, busy=0; stays so with tx_valid=0.
//   2. Send 0x55 (8N1) -> UART_TX = 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles,
//      40 cycles total; tx_ready low for 40 cycles after accept.
//   3. Hold tx_valid with 0x30 then 0x31 -> two frames decode to 0x30, 0x31;
//      exactly 1 idle-high cycle between the stop bit and the second start bit.
//   4. PARITY=2, send 0x07 -> parity bit=1. PARITY=1, send 0x07 -> parity bit=0.
//      Frame = 44 cycles.
//   5. Reset asserted during data bit 3 of 0xA5 -> UART_TX=1 with no clock edge;
//      after release, a new 0x3C frame is clean and correct.
//   6. While busy, pulse tx_valid with 0xFF -> ignored. The in-flight 0x12 frame is
//      unaffected, and no second frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, parity encodings and bit-period helper.
// Used by the transmit engine and the receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the last count.
// Held at zero while clear is high so every frame starts phase-aligned.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_tick = !clear && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: accepts a byte on valid/ready and sends start, LSB-first data,
// optional parity and stop bits with CLKS_PER_BIT timing on a registered line.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       UART_TX,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e state, state_next;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        stop_cnt;
  logic        par_bit;
  logic        line_next;
  logic        bit_tick;
  logic        accept;
  logic [7:0]  data_masked;

  assign accept      = (state == ST_IDLE) && tx_valid;
  assign data_masked = tx_data & DATA_MASK;
  assign busy        = (state != ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .bit_tick(bit_tick)
  );

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    line_next  = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_START;
      end
      ST_START: begin
        line_next = 1'b0;
        if (bit_tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        line_next = shift[0];
        if (bit_tick && bit_idx == LAST_BIT)
          state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_next = par_bit;
        if (bit_tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick && stop_cnt == LAST_STOP) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The line lags the state by one cycle, so the start bit appears on the edge
  // after acceptance; tx_ready tracks the next state so it drops at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      UART_TX  <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      UART_TX  <= line_next;
      tx_ready <= (state_next == ST_IDLE);
      if (accept) begin
        shift    <= data_masked;
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
        par_bit  <= (PARITY == PAR_ODD) ? ~(^data_masked) : ^data_masked;
      end else if (bit_tick && state == ST_DATA) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 3'd1;
      end else if (bit_tick && state == ST_STOP) begin
        stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: 8N1, 8E1 and 8O1 instances at 4 clocks per bit,
// compared cycle by cycle against a frame model built from the bit rules.
module tb_uart_tx_engine;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [2:0] ready_v, line_v, busy_v, valid_v;
  logic       rdy, line, bsy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign valid_v[0] = valid && (sel == 2'd0);
  assign valid_v[1] = valid && (sel == 2'd1);
  assign valid_v[2] = valid && (sel == 2'd2);

  uart_tx_engine #(.CLK_HZ(460800), .BAUD(115200), .PARITY(0)) dut_none (
    .clk(clk), .reset(reset), .tx_data(data), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .UART_TX(line_v[0]), .busy(busy_v[0]));

  uart_tx_engine #(.CLK_HZ(460800), .BAUD(115200), .PARITY(2)) dut_even (
    .clk(clk), .reset(reset), .tx_data(data), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .UART_TX(line_v[1]), .busy(busy_v[1]));

  uart_tx_engine #(.CLK_HZ(460800), .BAUD(115200), .PARITY(1)) dut_odd (
    .clk(clk), .reset(reset), .tx_data(data), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .UART_TX(line_v[2]), .busy(busy_v[2]));

  always_comb begin
    rdy  = ready_v[0];
    line = line_v[0];
    bsy  = busy_v[0];
    case (sel)
      2'd1: begin rdy = ready_v[1]; line = line_v[1]; bsy = busy_v[1]; end
      2'd2: begin rdy = ready_v[2]; line = line_v[2]; bsy = busy_v[2]; end
      default: ;
    endcase
  end

  function automatic int par_of(input logic [1:0] s);
    return (s == 2'd1) ? 2 : (s == 2'd2) ? 1 : 0;
  endfunction

  function automatic int frame_bits(input int par);
    return 1 + 8 + ((par != 0) ? 1 : 0) + 1;
  endfunction

  // Expected line level for bit position idx of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int par, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return logic'((int'(b) >> (idx - 1)) & 1);
    if (par != 0 && idx == 9) begin
      ones = $countones(b);
      return (par == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic observed, input logic expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "_line"}, line, 1'b1);
      check({tag, "_ready"}, rdy, 1'b1);
      check({tag, "_busy"}, bsy, 1'b0);
    end
  endtask

  // Presents byte b to instance s; returns just after the accepting edge.
  task automatic start_frame(input logic [1:0] s, input logic [7:0] b);
    int n;
    @(negedge clk);
    sel = s;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 1'b0, 1'b1);
    valid = 1'b1;
    data  = b;
    @(posedge clk);
  endtask

  // Checks the frame of byte b sample by sample, starting with the negedge after acceptance.
  task automatic check_frame(input logic [7:0] b, input bit keep_valid, input logic [7:0] next_b,
                             input int pulse_k, input int reset_k);
    int par, len;
    logic exp_line;
    par = par_of(sel);
    len = frame_bits(par) * CPB;
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (keep_valid) data = next_b;
        else begin
          valid = 1'b0;
          data  = 8'($urandom);
        end
      end
      if (k == pulse_k) begin
        valid = 1'b1;
        data  = 8'hFF;
      end
      if (k == pulse_k + 1) valid = 1'b0;
      exp_line = (k == 0) ? 1'b1 : frame_bit(b, par, (k - 1) / CPB);
      check("frame_line", line, exp_line);
      check("frame_ready", rdy, logic'(k == len));
      check("frame_busy", bsy, logic'(k != len));
      if (k == reset_k) begin
        reset = 1'b1;
        valid = 1'b0;
        #1;
        check("async_reset_line", line, 1'b1);
        check("async_reset_ready", rdy, 1'b1);
        check("async_reset_busy", bsy, 1'b0);
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic [1:0] rs;

    // Reset state, before and after release
    #12;
    check("reset_line", line, 1'b1);
    check("reset_ready", rdy, 1'b1);
    check("reset_busy", bsy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check_idle("post_reset", 8);

    // 0x55 8N1
    start_frame(2'd0, 8'h55);
    check_frame(8'h55, 1'b0, 8'h00, -10, -10);
    check_idle("after_55", 3);

    // Back-to-back 0x30 then 0x31 with tx_valid held
    start_frame(2'd0, 8'h30);
    check_frame(8'h30, 1'b1, 8'h31, -10, -10);
    check_frame(8'h31, 1'b0, 8'h00, -10, -10);
    check_idle("after_b2b", 3);

    // Parity: even then odd on 0x07
    start_frame(2'd1, 8'h07);
    check_frame(8'h07, 1'b0, 8'h00, -10, -10);
    start_frame(2'd2, 8'h07);
    check_frame(8'h07, 1'b0, 8'h00, -10, -10);
    check_idle("after_parity", 2);

    // Reset during data bit 3 of 0xA5, then a clean 0x3C
    start_frame(2'd0, 8'hA5);
    check_frame(8'hA5, 1'b0, 8'h00, -10, 4 * CPB + 2);
    repeat (2) @(negedge clk);
    check("in_reset_line", line, 1'b1);
    reset = 1'b0;
    check_idle("after_reset", 3);
    start_frame(2'd0, 8'h3C);
    check_frame(8'h3C, 1'b0, 8'h00, -10, -10);

    // tx_valid pulsed with 0xFF while 0x12 is in flight
    start_frame(2'd0, 8'h12);
    check_frame(8'h12, 1'b0, 8'h00, 10, -10);
    check_idle("after_ignored", 3 * CPB);

    // Random bytes on random instances with random idle gaps
    for (int i = 0; i < 12; i++) begin
      rs = 2'($urandom_range(0, 2));
      rb = 8'($urandom);
      start_frame(rs, rb);
      check_frame(rb, 1'b0, 8'h00, -10, -10);
      check_idle("rand_gap", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
